// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus bridge and its address decoder.
package periph_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } bridge_state_t;

   typedef logic [2:0] sel_t;

   localparam sel_t SEL_NONE  = 3'b000;
   localparam sel_t SEL_RAM   = 3'b001;
   localparam sel_t SEL_GPIO  = 3'b010;
   localparam sel_t SEL_TIMER = 3'b100;

   localparam logic [31:0] DEF_RAM_BASE      = 32'h0000_0000;
   localparam int unsigned DEF_RAM_SIZE_LOG2 = 12;
   localparam logic [31:0] DEF_GPIO_BASE     = 32'h1000_0000;
   localparam logic [31:0] DEF_TIMER_BASE    = 32'h1000_0100;
   localparam int unsigned DEF_RAM_WAIT      = 1;

   // GPIO and Timer each occupy a 16-byte window.
   localparam logic [31:0] WIN16_MASK = 32'hFFFF_FFF0;

   // Mask that keeps only the address bits above a 2**size_log2 byte window.
   function automatic logic [31:0] window_mask(input int unsigned size_log2);
      window_mask = ~((32'h0000_0001 << size_log2) - 32'h0000_0001);
   endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational byte-address decoder: one-hot peripheral select plus
// misaligned/unmapped flags, shared by any bus master on this peripheral bus.
module periph_addr_decode
   import periph_bus_pkg::*;
#(
   parameter logic [31:0] RAM_BASE      = DEF_RAM_BASE,
   parameter int unsigned RAM_SIZE_LOG2 = DEF_RAM_SIZE_LOG2,
   parameter logic [31:0] GPIO_BASE     = DEF_GPIO_BASE,
   parameter logic [31:0] TIMER_BASE    = DEF_TIMER_BASE
) (
   input  logic [31:0] addr,
   output logic [2:0]  sel,
   output logic        misaligned,
   output logic        unmapped
);

   localparam logic [31:0] RAM_MASK = window_mask(RAM_SIZE_LOG2);

   logic ram_hit_s;
   logic gpio_hit_s;
   logic timer_hit_s;

   assign ram_hit_s   = ((addr & RAM_MASK) == (RAM_BASE & RAM_MASK));
   assign gpio_hit_s  = ((addr & WIN16_MASK) == (GPIO_BASE & WIN16_MASK));
   assign timer_hit_s = ((addr & WIN16_MASK) == (TIMER_BASE & WIN16_MASK));

   // Fixed priority RAM > GPIO > Timer keeps the select one-hot if windows overlap.
   always_comb begin
      sel = SEL_NONE;
      if (ram_hit_s) begin
         sel = SEL_RAM;
      end else if (gpio_hit_s) begin
         sel = SEL_GPIO;
      end else if (timer_hit_s) begin
         sel = SEL_TIMER;
      end else begin
         sel = SEL_NONE;
      end
   end

   assign misaligned = (addr[1:0] != 2'b00);
   assign unmapped   = (sel == SEL_NONE);

endmodule

// File: rtl/periph_bus_bridge.sv
// Registered request/response bridge from the CPU memory stage to the RAM,
// GPIO and Timer peripherals; one access in flight, single-cycle response strobe.
module periph_bus_bridge
   import periph_bus_pkg::*;
#(
   parameter logic [31:0] RAM_BASE      = DEF_RAM_BASE,
   parameter int unsigned RAM_SIZE_LOG2 = DEF_RAM_SIZE_LOG2,
   parameter logic [31:0] GPIO_BASE     = DEF_GPIO_BASE,
   parameter logic [31:0] TIMER_BASE    = DEF_TIMER_BASE,
   parameter int unsigned RAM_WAIT      = DEF_RAM_WAIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_l_or_s,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        ram_sel,
   output logic        gpio_sel,
   output logic        timer_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_w_r,
   input  logic [31:0] ram_rdata,
   input  logic [31:0] gpio_rdata,
   input  logic [31:0] timer_rdata
);

   localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

   bridge_state_t state_r;
   logic [2:0]    sel_r;
   logic [3:0]    wait_cnt_r;
   logic [2:0]    dec_sel_s;
   logic          dec_misaligned_s;
   logic          dec_unmapped_s;
   logic          dec_err_s;
   logic [31:0]   rd_mux_s;

   periph_addr_decode #(
      .RAM_BASE      (RAM_BASE),
      .RAM_SIZE_LOG2 (RAM_SIZE_LOG2),
      .GPIO_BASE     (GPIO_BASE),
      .TIMER_BASE    (TIMER_BASE)
   ) u_decode (
      .addr       (req_addr),
      .sel        (dec_sel_s),
      .misaligned (dec_misaligned_s),
      .unmapped   (dec_unmapped_s)
   );

   assign dec_err_s = dec_misaligned_s | dec_unmapped_s;

   // Read-data mux driven by the registered select, so only the active target is sampled.
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      case (sel_r)
         SEL_RAM:   rd_mux_s = ram_rdata;
         SEL_GPIO:  rd_mux_s = gpio_rdata;
         SEL_TIMER: rd_mux_s = timer_rdata;
         default:   rd_mux_s = 32'h0000_0000;
      endcase
   end

   // Bridge FSM: request latch, wait counter, select drive and response capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         sel_r      <= SEL_NONE;
         wait_cnt_r <= 4'd0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= 32'h0000_0000;
         bus_addr   <= 32'h0000_0000;
         bus_wdata  <= 32'h0000_0000;
         bus_w_r    <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  bus_addr  <= req_addr;
                  bus_wdata <= req_wdata;
                  bus_w_r   <= req_l_or_s;
                  rsp_rdata <= 32'h0000_0000;
                  req_ready <= 1'b0;
                  if (dec_err_s) begin
                     // Bad address: answer immediately, never touch the bus.
                     state_r   <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state_r    <= ST_ACCESS;
                     sel_r      <= dec_sel_s;
                     wait_cnt_r <= (req_l_or_s && (dec_sel_s == SEL_RAM)) ? RAM_WAIT_C : 4'd0;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ST_ACCESS: begin
               if (!bus_w_r || (wait_cnt_r == 4'd0)) begin
                  state_r   <= ST_RESP;
                  sel_r     <= SEL_NONE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= bus_w_r ? rd_mux_s : 32'h0000_0000;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 4'd1;
               end
            end
            ST_RESP: begin
               state_r   <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state_r    <= ST_IDLE;
               sel_r      <= SEL_NONE;
               wait_cnt_r <= 4'd0;
               rsp_valid  <= 1'b0;
               rsp_err    <= 1'b0;
               req_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign ram_sel   = sel_r[0];
   assign gpio_sel  = sel_r[1];
   assign timer_sel = sel_r[2];

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Bench for periph_bus_bridge: directed test-plan transactions plus a random
// phase, all checked every cycle against a transaction-timeline model.
module tb_periph_bus_bridge;

   localparam int          RAM_WAIT  = 1;
   localparam logic [31:0] RAM_LIMIT = 32'h0000_1000;
   localparam logic [31:0] GPIO_LO   = 32'h1000_0000;
   localparam logic [31:0] TIMER_LO  = 32'h1000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_l_or_s = 1'b1;
   logic        req_ready, rsp_valid, rsp_err;
   logic        ram_sel, gpio_sel, timer_sel, bus_w_r;
   logic [31:0] rsp_rdata, bus_addr, bus_wdata;
   logic [31:0] ram_rdata = 32'h0;
   logic [31:0] gpio_rdata = 32'h0;
   logic [31:0] timer_rdata = 32'h0;

   int n_tests = 0;
   int n_fail  = 0;

   periph_bus_bridge #(.RAM_WAIT(RAM_WAIT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_l_or_s(req_l_or_s),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_sel(ram_sel), .gpio_sel(gpio_sel), .timer_sel(timer_sel),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_w_r(bus_w_r),
      .ram_rdata(ram_rdata), .gpio_rdata(gpio_rdata), .timer_rdata(timer_rdata)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Which peripheral an address reaches; 0 means the access must error.
   function automatic logic [2:0] target_of(input logic [31:0] a);
      if ((a % 32'd4) != 32'd0) return 3'b000;
      if (a < RAM_LIMIT) return 3'b001;
      if (a >= GPIO_LO && a < GPIO_LO + 32'd16) return 3'b010;
      if (a >= TIMER_LO && a < TIMER_LO + 32'd16) return 3'b100;
      return 3'b000;
   endfunction

   // Number of cycles the select stays high for an access.
   function automatic int lat_of(input logic [31:0] a, input logic ld);
      logic [2:0] t;
      t = target_of(a);
      if (t == 3'b000) return 0;
      if (ld && t == 3'b001) return 1 + RAM_WAIT;
      return 1;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] bnd [8];
      logic [31:0] a;
      bnd = '{32'h0000_0FFC, 32'h0000_1000, 32'h1000_000C, 32'h1000_0010,
              32'h1000_00FC, 32'h1000_010C, 32'h1000_0110, 32'h1000_0100};
      case ($urandom_range(0, 6))
         0, 1:    a = 32'($urandom_range(0, 4095)) & 32'h0000_0FFC;
         2:       a = GPIO_LO + 32'($urandom_range(0, 3) * 4);
         3:       a = TIMER_LO + 32'($urandom_range(0, 3) * 4);
         4:       a = bnd[$urandom_range(0, 7)];
         5:       a = $urandom & 32'hFFFF_FFFC;
         default: a = (($urandom_range(0, 1) == 1) ? GPIO_LO : 32'h0000_0100) + 32'($urandom_range(1, 3));
      endcase
      return a;
   endfunction

   // Model: tracks the single transaction in flight as (accept period, select length).
   int          edge_n = 0, free_edge = 0, acc_edge = 0, lat = 0;
   bit          have_txn = 1'b0, accepted_now = 1'b0, t_load = 1'b0, in_rand = 1'b0;
   logic [2:0]  t_sel = 3'b000;
   logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, exp_rdata = 32'h0;
   logic        m_wr = 1'b1;
   int          n_acc_rand = 0, n_rsp_rand = 0;

   always @(posedge clk) begin
      accepted_now <= 1'b0;
      edge_n       <= edge_n + 1;
      if (!rst) begin
         have_txn  <= 1'b0;
         free_edge <= 0;
         m_addr    <= 32'h0;
         m_wdata   <= 32'h0;
         m_wr      <= 1'b1;
      end else if (req_valid && (edge_n + 1) >= free_edge) begin
         accepted_now <= 1'b1;
         have_txn     <= 1'b1;
         acc_edge     <= edge_n + 1;
         t_sel        <= target_of(req_addr);
         t_load       <= req_l_or_s;
         lat          <= lat_of(req_addr, req_l_or_s);
         free_edge    <= edge_n + 1 + lat_of(req_addr, req_l_or_s) + 2;
         m_addr       <= req_addr;
         m_wdata      <= req_wdata;
         m_wr         <= req_l_or_s;
         if (in_rand) n_acc_rand <= n_acc_rand + 1;
      end
   end

   // Compare every DUT output against the model each cycle, away from the rising edge.
   always @(negedge clk) begin
      logic [2:0]  e_sel;
      logic        e_rv, e_rdy, e_wr;
      logic [31:0] e_addr, e_wdata, e_rdata;
      e_sel = 3'b000; e_rv = 1'b0; e_rdy = 1'b1;
      e_addr = m_addr; e_wdata = m_wdata; e_wr = m_wr;
      if (!rst) begin
         e_addr = 32'h0; e_wdata = 32'h0; e_wr = 1'b1;
      end else if (have_txn && edge_n >= acc_edge && edge_n <= acc_edge + lat) begin
         e_rdy = 1'b0;
         if (edge_n < acc_edge + lat) e_sel = t_sel;
         else e_rv = 1'b1;
         if (t_load && t_sel != 3'b000 && edge_n == acc_edge + lat - 1)
            exp_rdata <= (t_sel == 3'b001) ? ram_rdata : ((t_sel == 3'b010) ? gpio_rdata : timer_rdata);
      end
      e_rdata = (t_load && t_sel != 3'b000) ? exp_rdata : 32'h0;
      check32("m_sel", {29'h0, timer_sel, gpio_sel, ram_sel}, {29'h0, e_sel});
      check1("m_req_ready", req_ready, e_rdy);
      check1("m_rsp_valid", rsp_valid, e_rv);
      check32("m_bus_addr", bus_addr, e_addr);
      check32("m_bus_wdata", bus_wdata, e_wdata);
      check1("m_bus_w_r", bus_w_r, e_wr);
      if (e_rv) begin
         check1("m_rsp_err", rsp_err, (t_sel == 3'b000));
         check32("m_rsp_rdata", rsp_rdata, e_rdata);
      end
      if (in_rand && rsp_valid === 1'b1) n_rsp_rand <= n_rsp_rand + 1;
   end

   // One request from an idle bridge, with hand-written cycle-by-cycle expectations.
   task automatic directed(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic load, input logic [2:0] sel_exp, input int n_sel,
                           input logic err_exp, input logic [31:0] rdata_exp);
      req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_l_or_s = load;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < n_sel; c++) begin
         check32({name, "_sel"}, {29'h0, timer_sel, gpio_sel, ram_sel}, {29'h0, sel_exp});
         check1({name, "_ready_low"}, req_ready, 1'b0);
         check1({name, "_no_rsp"}, rsp_valid, 1'b0);
         check32({name, "_bus_addr"}, bus_addr, addr);
         check32({name, "_bus_wdata"}, bus_wdata, wdata);
         check1({name, "_bus_w_r"}, bus_w_r, load);
         @(posedge clk); #1;
      end
      check1({name, "_rsp_valid"}, rsp_valid, 1'b1);
      check1({name, "_rsp_err"}, rsp_err, err_exp);
      check32({name, "_rsp_rdata"}, rsp_rdata, rdata_exp);
      check32({name, "_rsp_sel"}, {29'h0, timer_sel, gpio_sel, ram_sel}, 32'h0);
      @(posedge clk); #1;
      check1({name, "_rsp_drop"}, rsp_valid, 1'b0);
      check1({name, "_ready_back"}, req_ready, 1'b1);
   endtask

   initial begin
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      check1("reset_ready", req_ready, 1'b1);
      check1("reset_rsp_valid", rsp_valid, 1'b0);
      check1("reset_bus_w_r", bus_w_r, 1'b1);
      check32("reset_bus_addr", bus_addr, 32'h0);
      check32("reset_sel", {29'h0, timer_sel, gpio_sel, ram_sel}, 32'h0);

      ram_rdata = 32'hCAFE_F00D; gpio_rdata = 32'h1111_1111; timer_rdata = 32'h0000_1234;
      directed("ram_load",         32'h0000_0040, 32'h0000_0000, 1'b1, 3'b001, 2, 1'b0, 32'hCAFE_F00D);
      directed("gpio_store",       32'h1000_0000, 32'h0000_00FF, 1'b0, 3'b010, 1, 1'b0, 32'h0);
      directed("timer_load",       32'h1000_0104, 32'hDEAD_BEEF, 1'b1, 3'b100, 1, 1'b0, 32'h0000_1234);
      directed("gpio_load",        32'h1000_000C, 32'h0000_0000, 1'b1, 3'b010, 1, 1'b0, 32'h1111_1111);
      directed("ram_store",        32'h0000_0FFC, 32'hA5A5_5A5A, 1'b0, 3'b001, 1, 1'b0, 32'h0);
      directed("unmapped_load",    32'h2000_0000, 32'h0000_0000, 1'b1, 3'b000, 0, 1'b1, 32'h0);
      directed("misaligned_store", 32'h0000_0042, 32'h5555_AAAA, 1'b0, 3'b000, 0, 1'b1, 32'h0);

      // Reset in the middle of a RAM load's access phase.
      req_valid = 1'b1; req_addr = 32'h0000_0080; req_l_or_s = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #3;
      check1("rst_pre_ram_sel", ram_sel, 1'b1);
      rst = 1'b0;
      #1;
      check32("rst_async_sel", {29'h0, timer_sel, gpio_sel, ram_sel}, 32'h0);
      check1("rst_async_rsp", rsp_valid, 1'b0);
      check1("rst_async_w_r", bus_w_r, 1'b1);
      @(posedge clk); #2 rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check1("rst_no_rsp", rsp_valid, 1'b0);
      end
      directed("post_rst_timer_load", 32'h1000_0100, 32'h0000_0000, 1'b1, 3'b100, 1, 1'b0, 32'h0000_1234);

      // Random phase: request held until accepted, peripheral data changing every cycle.
      in_rand = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         ram_rdata = $urandom; gpio_rdata = $urandom; timer_rdata = $urandom;
         if (accepted_now || !req_valid) begin
            if ($urandom_range(0, 3) == 0) begin
               req_valid = 1'b0;
            end else begin
               req_valid  = 1'b1;
               req_addr   = rand_addr();
               req_wdata  = $urandom;
               req_l_or_s = 1'($urandom_range(0, 1));
            end
         end
      end
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      in_rand = 1'b0;
      check32("rand_rsp_count", 32'(n_rsp_rand), 32'(n_acc_rand));
      check1("rand_accept_min", (n_acc_rand > 300), 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
